// File: rtl/bike_bram_port_arbiter.sv
// Round-robin arbiter sharing one BIKE BRAM port between NREQ requesters, with registered
// command issue and tagged read return. Define BIKE_ARB_LOCK_EN to add req_lock bursts.
module bike_bram_port_arbiter #(
   parameter int NREQ   = 4,
   parameter int AW     = 10,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
`ifdef BIKE_ARB_LOCK_EN
   input  logic [NREQ-1:0]      req_lock,
`endif
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   output logic                 busy,
   output logic                 bram_ren,
   output logic                 bram_wen,
   output logic [AW-1:0]        bram_addr,
   output logic [DW-1:0]        bram_din,
   input  logic [DW-1:0]        bram_dout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] rr_idx;
   logic          rr_found;
   logic [PW:0]   cand;
   logic [PW-1:0] win_idx;
   logic          win_found;
   logic [NREQ-1:0] gnt_v;

   logic          bram_ren_q, bram_ren_d;
   logic          bram_wen_q, bram_wen_d;
   logic [AW-1:0] bram_addr_q, bram_addr_d;
   logic [DW-1:0] bram_din_q, bram_din_d;
   logic [PW-1:0] rd_id_q, rd_id_d;

   logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [PW-1:0]     tag_id_q [RD_LAT];
   logic [PW-1:0]     tag_id_d [RD_LAT];

`ifdef BIKE_ARB_LOCK_EN
   typedef enum logic {S_IDLE, S_LOCKED} lock_state_e;
   lock_state_e   state_q, state_d;
   logic [PW-1:0] lock_id_q, lock_id_d;
`endif

   // First asserted request scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!rr_found && req[cand[PW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      win_found = rr_found;
      win_idx   = rr_idx;
      ptr_d     = ptr_q;
`ifdef BIKE_ARB_LOCK_EN
      state_d   = state_q;
      lock_id_d = lock_id_q;
      if (state_q == S_LOCKED) begin
         win_found = req[lock_id_q];
         win_idx   = lock_id_q;
      end
`endif
      // gnt must read 0 while reset is held, even with requests pending.
      win_found = win_found & resetn;
      gnt_v = '0;
      if (win_found) gnt_v[win_idx] = 1'b1;
`ifdef BIKE_ARB_LOCK_EN
      if (state_q == S_IDLE) begin
         if (win_found && req_lock[win_idx]) begin
            state_d   = S_LOCKED;
            lock_id_d = win_idx;
         end
      end else if (!req_lock[lock_id_q]) begin
         state_d = S_IDLE;
      end
`endif
      if (win_found) begin
         if (win_idx == PW'(NREQ-1)) ptr_d = '0;
         else                        ptr_d = win_idx + 1'b1;
`ifdef BIKE_ARB_LOCK_EN
         if (state_d == S_LOCKED) ptr_d = win_idx;
`endif
      end
   end

   always_comb begin
      bram_ren_d  = 1'b0;
      bram_wen_d  = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_din_d  = bram_din_q;
      rd_id_d     = rd_id_q;
      if (win_found) begin
         bram_ren_d  = !req_we[win_idx];
         bram_wen_d  = req_we[win_idx];
         bram_addr_d = req_addr[int'(win_idx)*AW +: AW];
         bram_din_d  = req_wdata[int'(win_idx)*DW +: DW];
         rd_id_d     = win_idx;
      end
   end

   // Tag stage 0 follows the issued command, so the last stage lines up with bram_dout.
   always_comb begin
      tag_vld_d    = '0;
      tag_vld_d[0] = bram_ren_q;
      tag_id_d[0]  = rd_id_q;
      for (int s = 1; s < RD_LAT; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_id_d[s]  = tag_id_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ptr_q       <= '0;
         bram_ren_q  <= 1'b0;
         bram_wen_q  <= 1'b0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
         rd_id_q     <= '0;
         tag_vld_q   <= '0;
         for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         bram_ren_q  <= bram_ren_d;
         bram_wen_q  <= bram_wen_d;
         bram_addr_q <= bram_addr_d;
         bram_din_q  <= bram_din_d;
         rd_id_q     <= rd_id_d;
         tag_vld_q   <= tag_vld_d;
         for (int s = 0; s < RD_LAT; s++) tag_id_q[s] <= tag_id_d[s];
      end
   end

`ifdef BIKE_ARB_LOCK_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end
`endif

   always_comb begin
      rvalid = '0;
      if (tag_vld_q[RD_LAT-1]) rvalid[tag_id_q[RD_LAT-1]] = 1'b1;
   end

   assign gnt       = gnt_v;
   assign rdata     = bram_dout;
   assign busy      = bram_ren_q | bram_wen_q | (|tag_vld_q);
   assign bram_ren  = bram_ren_q;
   assign bram_wen  = bram_wen_q;
   assign bram_addr = bram_addr_q;
   assign bram_din  = bram_din_q;

endmodule

// File: tb/tb_bike_bram_port_arbiter.sv
// Bench for bike_bram_port_arbiter: two instances (RD_LAT 1 and 3) share stimulus and are
// compared every cycle against a transaction-level model, plus hand-computed pins.
module tb_bike_bram_port_arbiter;

   logic         clk = 1'b0;
   logic         resetn;
   logic [3:0]   req, req_we;
   logic [39:0]  req_addr;
   logic [127:0] req_wdata;
`ifdef BIKE_ARB_LOCK_EN
   logic [3:0]   req_lock;
`endif

   logic [3:0]  g1, rv1, g3, rv3;
   logic [31:0] rd1, rd3, din1, din3, dout1, dout3, s1_3, s2_3;
   logic        busy1, busy3, ren1, ren3, wen1, wen3;
   logic [9:0]  addr1, addr3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bike_bram_port_arbiter #(.NREQ(4), .AW(10), .DW(32), .RD_LAT(1)) dut1 (
      .clk(clk), .resetn(resetn), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata),
`ifdef BIKE_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .gnt(g1), .rvalid(rv1), .rdata(rd1), .busy(busy1), .bram_ren(ren1), .bram_wen(wen1),
      .bram_addr(addr1), .bram_din(din1), .bram_dout(dout1));

   bike_bram_port_arbiter #(.NREQ(4), .AW(10), .DW(32), .RD_LAT(3)) dut3 (
      .clk(clk), .resetn(resetn), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata),
`ifdef BIKE_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .gnt(g3), .rvalid(rv3), .rdata(rd3), .busy(busy3), .bram_ren(ren3), .bram_wen(wen3),
      .bram_addr(addr3), .bram_din(din3), .bram_dout(dout3));

   // BRAM models: unwritten words read as C0DE0000 | addr.
   logic [31:0]   mem1 [1024];
   logic [31:0]   mem3 [1024];
   logic [1023:0] wf1 = '0;
   logic [1023:0] wf3 = '0;

   always @(posedge clk) begin
      if (wen1) begin
         mem1[addr1] <= din1;
         wf1[addr1]  <= 1'b1;
      end
      dout1 <= wf1[addr1] ? mem1[addr1] : (32'hC0DE0000 | 32'(addr1));
   end

   always @(posedge clk) begin
      if (wen3) begin
         mem3[addr3] <= din3;
         wf3[addr3]  <= 1'b1;
      end
      s1_3  <= wf3[addr3] ? mem3[addr3] : (32'hC0DE0000 | 32'(addr3));
      s2_3  <= s1_3;
      dout3 <= s2_3;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level model: expected reads queued with their due cycle.
   typedef struct {
      int          due;
      logic [3:0]  oh;
      logic [31:0] data;
   } rd_t;

   rd_t         exp_q1[$];
   rd_t         exp_q3[$];
   logic [31:0] m_wr [int];
   int          m_ptr;
   logic        e_ren, e_wen;
   logic [9:0]  e_addr;
   logic [31:0] e_din;

   initial begin
      logic [3:0]  eg, erv;
      logic [31:0] erd, d;
      logic [9:0]  a;
      logic        b1, b3, found;
      int          k, j;
      m_ptr = 0; e_ren = 0; e_wen = 0; e_addr = '0; e_din = '0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            chk("rst_out1", {g1, rv1, busy1, ren1, wen1, addr1, din1}, 64'd0);
            chk("rst_out3", {g3, rv3, busy3, ren3, wen3, addr3, din3}, 64'd0);
            m_ptr = 0;
            exp_q1.delete();
            exp_q3.delete();
            e_ren = 0; e_wen = 0; e_addr = '0; e_din = '0;
         end else begin
            b1 = e_ren | e_wen;
            b3 = e_ren | e_wen;
            foreach (exp_q1[n]) if (exp_q1[n].due - 1 < cyc) b1 = 1'b1;
            foreach (exp_q3[n]) if (exp_q3[n].due - 3 < cyc) b3 = 1'b1;
            chk("busy1", busy1, b1);
            chk("busy3", busy3, b3);
            chk("issue1", {ren1, wen1, addr1, din1}, {e_ren, e_wen, e_addr, e_din});
            chk("issue3", {ren3, wen3, addr3, din3}, {e_ren, e_wen, e_addr, e_din});

            erv = '0; erd = '0;
            if (exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
               erv = exp_q1[0].oh; erd = exp_q1[0].data; void'(exp_q1.pop_front());
            end
            chk("rvalid1", rv1, erv);
            if (erv != 0) chk("rdata1", rd1, erd);
            erv = '0; erd = '0;
            if (exp_q3.size() > 0 && exp_q3[0].due == cyc) begin
               erv = exp_q3[0].oh; erd = exp_q3[0].data; void'(exp_q3.pop_front());
            end
            chk("rvalid3", rv3, erv);
            if (erv != 0) chk("rdata3", rd3, erd);

            found = 1'b0; k = 0;
            for (int o = 0; o < 4; o++) begin
               j = (m_ptr + o) % 4;
               if (!found && req[j]) begin
                  found = 1'b1;
                  k = j;
               end
            end
            eg = found ? 4'(1 << k) : 4'd0;
            chk("gnt1", g1, eg);
            chk("gnt3", g3, eg);

            e_ren = 1'b0; e_wen = 1'b0;
            if (found) begin
               a      = req_addr[k*10 +: 10];
               e_ren  = !req_we[k];
               e_wen  = req_we[k];
               e_addr = a;
               e_din  = req_wdata[k*32 +: 32];
               if (req_we[k]) begin
                  m_wr[int'(a)] = e_din;
               end else begin
                  d = m_wr.exists(int'(a)) ? m_wr[int'(a)] : (32'hC0DE0000 | 32'(a));
                  exp_q1.push_back('{cyc + 2, 4'(1 << k), d});
                  exp_q3.push_back('{cyc + 4, 4'(1 << k), d});
               end
               m_ptr = (k + 1) % 4;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_req(input int i, input logic we, input logic [9:0] a, input logic [31:0] d);
      req[i]                = 1'b1;
      req_we[i]             = we;
      req_addr[i*10 +: 10]  = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic clr();
      req    = '0;
      req_we = '0;
   endtask

   // {req mask, write mask} per pattern; pairs 0/1 and 2/3 share an address.
   logic [7:0] pats [8] = '{8'hF5, 8'h31, 8'h32, 8'hC8, 8'hA0, 8'h55, 8'hF0, 8'h99};

   initial begin
      logic [7:0] p;
      logic [3:0] pend;
      resetn = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef BIKE_ARB_LOCK_EN
      req_lock = '0;
`endif
      repeat (3) step();
      settle();
      chk("pin_rst", {g1, busy1, ren1, rv3}, 64'd0);
      step(); resetn = 1'b1;

      // Single read from requester 2.
      step(); set_req(2, 1'b0, 10'h005, 32'd0); settle();
      chk("pin_t1_gnt", g1, 4'b0100);
      step(); clr(); settle();
      chk("pin_t1_issue", {ren1, addr1}, {1'b1, 10'h005});
      step(); settle();
      chk("pin_t1_rvalid", rv1, 4'b0100);
      chk("pin_t1_rdata", rd1, 32'hC0DE0005);

      // ptr is 3: requester 3 beats requester 0.
      step(); set_req(3, 1'b0, 10'h013, 32'd0); set_req(0, 1'b0, 10'h010, 32'd0); settle();
      chk("pin_ptr3", g1, 4'b1000);
      step(); set_req(1, 1'b0, 10'h011, 32'd0); set_req(2, 1'b0, 10'h012, 32'd0);
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("pin_rr", g1, 64'(1 << (i % 4)));
         step();
      end
      clr();

      // Write then read back at the top address.
      step(); set_req(1, 1'b1, 10'h3FF, 32'hDEADBEEF); settle();
      chk("pin_wr_gnt", g1, 4'b0010);
      step(); set_req(1, 1'b0, 10'h3FF, 32'd0); settle();
      chk("pin_rd_gnt", g1, 4'b0010);
      chk("pin_wr_issue", {wen1, ren1, addr1, din1}, {1'b1, 1'b0, 10'h3FF, 32'hDEADBEEF});
      step(); clr(); settle();
      chk("pin_rd_issue", {wen1, ren1}, 2'b01);
      step(); settle();
      chk("pin_rb_rvalid", rv1, 4'b0010);
      chk("pin_rb_rdata", rd1, 32'hDEADBEEF);

      // Reset while two reads are in flight.
      step(); set_req(0, 1'b0, 10'h007, 32'd0); set_req(1, 1'b0, 10'h008, 32'd0); settle();
      chk("pin_t4_gnt0", g1, 4'b0001);
      step(); clr(); set_req(1, 1'b0, 10'h008, 32'd0); settle();
      chk("pin_t4_gnt1", g1, 4'b0010);
      step(); clr(); resetn = 1'b0; settle();
      chk("pin_t4_rst1", {g1, rv1, busy1, ren1, addr1}, 64'd0);
      chk("pin_t4_rst3", {rv3, busy3, ren3, addr3}, 64'd0);
      step(); step(); resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("pin_no_stale_rv", {rv1, rv3}, 64'd0);
         step();
      end
      set_req(0, 1'b0, 10'h009, 32'd0); set_req(3, 1'b0, 10'h00A, 32'd0); settle();
      chk("pin_ptr0_after_rst", g1, 4'b0001);
      step(); clr();

      // Back-to-back reads 0,1,2; RD_LAT 3 returns in cycles 4,5,6.
      set_req(3, 1'b1, 10'h030, 32'h00001234);
      step(); clr();
      set_req(0, 1'b0, 10'h020, 32'd0); set_req(1, 1'b0, 10'h021, 32'd0);
      set_req(2, 1'b0, 10'h022, 32'd0); settle();
      chk("pin_b2b_g0", g3, 4'b0001);
      step(); req[0] = 1'b0; settle();
      chk("pin_b2b_g1", g3, 4'b0010);
      step(); req[1] = 1'b0; settle();
      chk("pin_b2b_g2", g3, 4'b0100);
      step(); clr(); settle();
      chk("pin_c3", {rv1, rv3}, {4'b0010, 4'b0000});
      step(); settle();
      chk("pin_c4_rv", {rv3, rv1}, {4'b0001, 4'b0100});
      chk("pin_c4_rd", {rd3, rd1}, {32'hC0DE0020, 32'hC0DE0022});
      step(); settle();
      chk("pin_c5", {rv3, rd3}, {4'b0010, 32'hC0DE0021});
      step(); settle();
      chk("pin_c6", {rv3, rd3, busy3}, {4'b0100, 32'hC0DE0022, 1'b1});
      step(); settle();
      chk("pin_c7_idle", {busy3, busy1}, 2'b00);
      step();

      // Mixed patterns, each requester holding until granted.
      for (int e = 0; e < 8; e++) begin
         p    = pats[e];
         pend = p[7:4];
         for (int i = 0; i < 4; i++) begin
            req_we[i]             = p[i];
            req_addr[i*10 +: 10]  = 10'h100 + 10'(i >> 1);
            req_wdata[i*32 +: 32] = 32'hA0000000 + 32'(e * 16 + i);
         end
         for (int c = 0; c < 8 && pend != 0; c++) begin
            req = pend;
            settle();
            pend = pend & ~g1;
            step();
         end
         chk("hs_timeout", pend, 64'd0);
         req = '0;
      end
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
